// File: rtl/dpi_fb_pkg.sv
// dpi_fb_pkg: shared state encoding, matrix defaults, derived widths and pixel type
package dpi_fb_pkg;
  typedef enum logic [1:0] {IDLE, CAPTURE, READY, SKIP} state_t;
  localparam int MAT_W_DEF = 64;
  localparam int MAT_H_DEF = 32;
  localparam int COL_W = $clog2(MAT_W_DEF);
  localparam int ROW_W = $clog2(MAT_H_DEF);
  localparam int ADDR_W = 1 + ROW_W + COL_W;
  typedef logic [23:0] pixel_t;
  function automatic logic [7:0] sat_inc(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction
endpackage

// File: rtl/dpi_win_map.sv
// dpi_win_map: maps a source pixel coordinate onto the captured window (hit, row, col)
module dpi_win_map import dpi_fb_pkg::*; #(
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int MAT_W = MAT_W_DEF,
  parameter int MAT_H = MAT_H_DEF,
  localparam int CW = $clog2(MAT_W),
  localparam int RW = $clog2(MAT_H)
) (
  input  logic [10:0]   x,
  input  logic [9:0]    y,
  output logic          hit,
  output logic [RW-1:0] row,
  output logic [CW-1:0] col
);
  assign hit = int'(x) >= WIN_X0 && int'(x) < WIN_X0 + MAT_W &&
               int'(y) >= WIN_Y0 && int'(y) < WIN_Y0 + MAT_H;
  assign row = RW'(y - 10'(WIN_Y0));
  assign col = CW'(x - 11'(WIN_X0));
endmodule

// File: rtl/dpi_fb_writer.sv
// dpi_fb_writer: captures a window of the DPI pixel stream into a double-buffered
// frame buffer and hands completed frames to the matrix scanner.
module dpi_fb_writer import dpi_fb_pkg::*; #(
  parameter int WIN_X0 = 0,
  parameter int WIN_Y0 = 0,
  parameter int MAT_W = MAT_W_DEF,
  parameter int MAT_H = MAT_H_DEF,
  localparam int CW = $clog2(MAT_W),
  localparam int RW = $clog2(MAT_H),
  localparam int AW = 1 + RW + CW
) (
  input  logic          PCLK,
  input  logic          RESET,
  input  logic          ENABLE,
  input  logic [10:0]   ADDR_H,
  input  logic [9:0]    ADDR_V,
  input  logic [7:0]    Q_RED,
  input  logic [7:0]    Q_GREEN,
  input  logic [7:0]    Q_BLUE,
  input  logic          DE,
  input  logic          VSYNC,
  input  logic          RD_ACK,
  output logic          WR_EN,
  output logic [AW-1:0] WR_ADDR,
  output pixel_t        WR_DATA,
  output logic          RD_BANK,
  output logic          FRAME_READY,
  output logic [7:0]    DROP_CNT
);
  state_t state_q;
  logic de_q, vs_q, wr_bank_q, rd_bank_q, wr_en_q, ready_q;
  logic [AW-1:0] addr_q;
  pixel_t data_q;
  logic [7:0] drop_q;
  logic [10:0] px_x;
  logic [9:0] px_y;
  logic hit, vs_edge, wr, last;
  logic [RW-1:0] row;
  logic [CW-1:0] col;
  // the receiver count already advanced past the registered pixel
  assign px_x = ADDR_H - 11'd1;
  assign px_y = ADDR_V - 10'd1;
  dpi_win_map #(.WIN_X0(WIN_X0), .WIN_Y0(WIN_Y0), .MAT_W(MAT_W), .MAT_H(MAT_H)) u_map (
    .x(px_x), .y(px_y), .hit(hit), .row(row), .col(col)
  );
  assign vs_edge = VSYNC & ~vs_q;
  assign wr = ENABLE && state_q == CAPTURE && de_q && hit;
  assign last = &{row, col};
  always_ff @(posedge PCLK or posedge RESET)
    if (RESET) begin
      state_q <= IDLE;
      de_q <= 1'b0;
      vs_q <= 1'b0;
      wr_bank_q <= 1'b0;
      rd_bank_q <= 1'b1;
      wr_en_q <= 1'b0;
      addr_q <= '0;
      data_q <= '0;
      ready_q <= 1'b0;
      drop_q <= '0;
    end else begin
      de_q <= DE;
      vs_q <= VSYNC;
      wr_en_q <= 1'b0;
      if (!ENABLE) state_q <= IDLE;
      else case (state_q)
        IDLE: if (vs_edge) state_q <= CAPTURE;
        CAPTURE: begin
          if (wr) begin
            wr_en_q <= 1'b1;
            addr_q <= {wr_bank_q, row, col};
            data_q <= {Q_RED, Q_GREEN, Q_BLUE};
          end
          if (wr && last) begin
            ready_q <= 1'b1;
            state_q <= READY;
          end else if (vs_edge) drop_q <= sat_inc(drop_q);
        end
        READY, SKIP: if (RD_ACK) begin
          rd_bank_q <= wr_bank_q;
          wr_bank_q <= ~wr_bank_q;
          ready_q <= 1'b0;
          state_q <= (state_q == READY && vs_edge) ? CAPTURE : IDLE;
        end else if (vs_edge) begin
          drop_q <= sat_inc(drop_q);
          state_q <= SKIP;
        end
      endcase
    end
  assign WR_EN = wr_en_q;
  assign WR_ADDR = addr_q;
  assign WR_DATA = data_q;
  assign RD_BANK = rd_bank_q;
  assign FRAME_READY = ready_q;
  assign DROP_CNT = drop_q;
endmodule

// File: tb/tb_dpi_fb_writer.sv
// tb_dpi_fb_writer: directed frames on a scaled window, scoreboarded write stream
module tb_dpi_fb_writer;
  localparam int WX = 3, WY = 2, MW = 16, MH = 8, HT = 32, HA = 24, VA = 12;
  typedef struct packed {logic [7:0] addr; logic [23:0] data; logic last;} exp_t;
  logic clk = 1'b0;
  logic rst, en, de, vs, ack;
  logic [10:0] ah;
  logic [9:0] av;
  logic [7:0] qr, qg, qb;
  logic wr_en, rd_bank, frame_ready;
  logic [7:0] wr_addr, drop_cnt;
  logic [23:0] wr_data;
  exp_t exp_q[$];
  int checks = 0, errors = 0, wcount = 0;
  bit cap = 0, bank = 0;
  logic [10:0] ph = '0;
  logic [9:0] pv = '0;
  logic [23:0] pq = '0;

  always #5 clk = ~clk;

  dpi_fb_writer #(.WIN_X0(WX), .WIN_Y0(WY), .MAT_W(MW), .MAT_H(MH)) dut (
    .PCLK(clk), .RESET(rst), .ENABLE(en), .ADDR_H(ah), .ADDR_V(av),
    .Q_RED(qr), .Q_GREEN(qg), .Q_BLUE(qb), .DE(de), .VSYNC(vs), .RD_ACK(ack),
    .WR_EN(wr_en), .WR_ADDR(wr_addr), .WR_DATA(wr_data), .RD_BANK(rd_bank),
    .FRAME_READY(frame_ready), .DROP_CNT(drop_cnt)
  );

  function automatic logic [23:0] pix(input int x, input int y);
    return (x == WX && y == WY) ? 24'h123456 : {8'(x), 8'(y), 8'hA5 ^ 8'(x + y)};
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", nm, act, req);
    end
  endtask

  // receiver view lags the raw DE by one cycle and carries count = coordinate + 1
  task automatic cyc(input bit d, input int x, input int y, input bit v, input bit a);
    de = d; vs = v; ack = a;
    ah = ph; av = pv; {qr, qg, qb} = pq;
    ph = 11'(x + 1); pv = 10'(y + 1); pq = pix(x, y);
    @(posedge clk); #1;
  endtask

  task automatic px(input int x, input int y);
    logic d, l;
    d = x < HA && y < VA;
    l = x == WX + MW - 1 && y == WY + MH - 1;
    if (d && cap && x >= WX && x < WX + MW && y >= WY && y < WY + MH) begin
      exp_q.push_back('{addr: {bank, 3'(y - WY), 4'(x - WX)}, data: pix(x, y), last: l});
      if (l) cap = 0;
    end
    cyc(d, x, y, 0, 0);
  endtask

  task automatic frame(input int n);
    for (int y = 0; y < n; y++)
      for (int x = 0; x < HT; x++) px(x, y);
  endtask

  task automatic vs_pulse(input bit a);
    cyc(0, 0, 0, 1, a); cyc(0, 0, 0, 1, 0); cyc(0, 0, 0, 0, 0);
  endtask

  task automatic ack_pulse();
    cyc(0, 0, 0, 0, 1); cyc(0, 0, 0, 0, 0);
  endtask

  always @(negedge clk)
    if (wr_en) begin
      exp_t e;
      wcount++;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write actual addr=%h data=%h required no write", wr_addr, wr_data);
      end else begin
        e = exp_q.pop_front();
        if ({wr_addr, wr_data, frame_ready} !== {e.addr, e.data, e.last} || wr_addr[7] === rd_bank) begin
          errors++;
          $display("FAIL write actual addr=%h data=%h ready=%b rd_bank=%b required addr=%h data=%h ready=%b",
                   wr_addr, wr_data, frame_ready, rd_bank, e.addr, e.data, e.last);
        end
      end
    end

  initial begin
    rst = 1; en = 1; de = 0; vs = 0; ack = 0; ah = '0; av = '0; {qr, qg, qb} = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_wr_en", wr_en, 0); chk("rst_wr_addr", wr_addr, 0); chk("rst_wr_data", wr_data, 0);
    chk("rst_rd_bank", rd_bank, 1); chk("rst_ready", frame_ready, 0); chk("rst_drop", drop_cnt, 0);
    rst = 0;
    frame(VA);
    vs_pulse(0); cap = 1; bank = 0;
    frame(VA);
    chk("frame_a_writes", wcount, 128); chk("frame_a_ready", frame_ready, 1); chk("frame_a_rd_bank", rd_bank, 1);
    repeat (10) cyc(0, 0, 0, 0, 0);
    ack_pulse(); bank = 1;
    chk("swap_a_rd_bank", rd_bank, 0); chk("swap_a_ready", frame_ready, 0);
    vs_pulse(0); cap = 1;
    frame(VA);
    chk("frame_b_ready", frame_ready, 1);
    repeat (3) begin vs_pulse(0); frame(VA); end
    chk("withheld_drop", drop_cnt, 3); chk("withheld_ready", frame_ready, 1); chk("withheld_rd_bank", rd_bank, 0);
    ack_pulse(); bank = 0;
    chk("swap_b_rd_bank", rd_bank, 1); chk("swap_b_ready", frame_ready, 0);
    frame(VA);
    vs_pulse(0); cap = 1;
    frame(6);
    ack_pulse();
    chk("ack_in_capture", rd_bank, 1);
    vs_pulse(0);
    chk("abort_drop", drop_cnt, 4);
    frame(VA);
    chk("frame_c_ready", frame_ready, 1); chk("total_writes", wcount, 128 * 3 + 64);
    vs_pulse(1); bank = 1; cap = 1;
    chk("ack_vs_rd_bank", rd_bank, 0); chk("ack_vs_drop", drop_cnt, 4); chk("ack_vs_ready", frame_ready, 0);
    frame(5);
    en = 0; cap = 0;
    for (int x = 0; x < HT; x++) px(x, 5);
    en = 1;
    ack_pulse();
    chk("disable_rd_bank", rd_bank, 0); chk("disable_ready", frame_ready, 0);
    vs_pulse(0); cap = 1;
    frame(VA);
    chk("frame_d_ready", frame_ready, 1);
    repeat (260) vs_pulse(0);
    chk("drop_saturate", drop_cnt, 255);
    ack_pulse(); bank = 0;
    chk("swap_d_rd_bank", rd_bank, 1);
    vs_pulse(0); cap = 1;
    frame(4);
    for (int x = 0; x < 10; x++) px(x, 4);
    rst = 1;
    #1;
    chk("abort_wr_en", wr_en, 0); chk("abort_wr_addr", wr_addr, 0); chk("abort_wr_data", wr_data, 0);
    chk("abort_rd_bank", rd_bank, 1); chk("abort_ready", frame_ready, 0); chk("abort_drop_cnt", drop_cnt, 0);
    exp_q.delete(); cap = 0; bank = 0;
    @(posedge clk); #1;
    rst = 0;
    frame(VA);
    vs_pulse(0); cap = 1;
    frame(VA);
    chk("post_rst_ready", frame_ready, 1); chk("post_rst_rd_bank", rd_bank, 1);
    repeat (4) cyc(0, 0, 0, 0, 0);
    chk("queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/dpi_fb_writer.md
DPI_FB_WRITER -- requirements
Module: dpi_fb_writer

Interface
REQ-001 Parameters SHALL be: WIN_X0 default 0, left edge of the captured window in source pixels; WIN_Y0 default 0, top edge of the captured window in source lines; MAT_W default 64, window width, power of two; MAT_H default 32, window height, power of two.
REQ-002 PCLK  in  1  pixel clock; all logic is clocked on the rising edge.
REQ-003 RESET  in  1  reset, asynchronous, active-high.
REQ-004 ENABLE  in  1  capture enable, level-sensitive.
REQ-005 ADDR_H  in  11  receiver horizontal count.
REQ-006 ADDR_V  in  10  receiver vertical count.
REQ-007 Q_RED, Q_GREEN, Q_BLUE  in  8 each  registered receiver pixel.
REQ-008 DE  in  1  raw data enable, also fed to the receiver.
REQ-009 VSYNC  in  1  raw vertical sync, active-high.
REQ-010 RD_ACK  in  1  one-cycle pulse from the matrix scanner: it has latched RD_BANK and released the other bank.
REQ-011 WR_EN  out  1  frame-buffer write strobe.
REQ-012 WR_ADDR  out  1+log2(MAT_H)+log2(MAT_W)  {bank, row, col}.
REQ-013 WR_DATA  out  24  {R,G,B}.
REQ-014 RD_BANK  out  1  bank the scanner shall display.
REQ-015 FRAME_READY  out  1  a complete frame waits in the write bank.
REQ-016 DROP_CNT  out  8  count of dropped or aborted frames, saturating.

Function
REQ-017 The block SHALL register DE into de_q; a pixel is valid when de_q=1, with coordinate x=ADDR_H-1, y=ADDR_V-1 (11/10-bit modular), and data Q_*.
REQ-018 A valid pixel is in-window when WIN_X0<=x<WIN_X0+MAT_W and WIN_Y0<=y<WIN_Y0+MAT_H.
REQ-019 Write address SHALL be {wr_bank, (y-WIN_Y0) truncated, (x-WIN_X0) truncated}.
REQ-020 WR_EN/WR_ADDR/WR_DATA SHALL be registered: asserted exactly 1 PCLK after the valid pixel, i.e. 2 PCLK after DE sampled high.
REQ-021 A VSYNC rising edge is defined as VSYNC=1 with the previous-cycle VSYNC sample =0.
REQ-022 The FSM SHALL have states IDLE, CAPTURE, READY and SKIP.
REQ-023 IDLE: no writes; on VSYNC edge with ENABLE=1 -> CAPTURE.
REQ-024 CAPTURE: in-window pixels are written; a write at (MAT_W-1, MAT_H-1) sets FRAME_READY=1 and moves to READY.
REQ-025 CAPTURE: a VSYNC edge before the last pixel SHALL increment DROP_CNT and stay in CAPTURE, overwriting the same bank.
REQ-026 READY: no writes; on RD_ACK, RD_BANK<=wr_bank, wr_bank<=~wr_bank, FRAME_READY<=0, -> IDLE.
REQ-027 READY: on VSYNC edge without RD_ACK, DROP_CNT increments and the FSM moves to SKIP.
REQ-028 READY: RD_ACK coinciding with a VSYNC edge SHALL perform the swap and go directly to CAPTURE, with no drop counted.
REQ-029 SKIP: no writes, FRAME_READY stays 1; on RD_ACK, perform the swap -> IDLE; on VSYNC edge without RD_ACK, increment DROP_CNT.
REQ-030 RD_ACK SHALL be ignored in IDLE and CAPTURE.
REQ-031 ENABLE=0 SHALL force IDLE on the next cycle and suppress WR_EN; FRAME_READY, RD_BANK and wr_bank are retained.
REQ-032 DROP_CNT SHALL saturate at 255.
REQ-033 The bank written SHALL never equal RD_BANK while WR_EN=1.

Reset
REQ-034 RESET SHALL force: state IDLE, wr_bank=0, RD_BANK=1, WR_EN=0, WR_ADDR=0, WR_DATA=0, FRAME_READY=0, DROP_CNT=0, de_q=0, and VSYNC history=0.
REQ-035 RESET mid-frame SHALL abort capture immediately; after release, the block waits for a fresh VSYNC edge.

Structure
REQ-036 Package dpi_fb_pkg SHALL hold the state enumeration, MAT_W/MAT_H defaults, derived column, row and address widths, and the 24-bit pixel typedef.
REQ-037 The window compare and offset logic SHALL be the combinational sub-module dpi_win_map, with inputs x, y and outputs hit, row, col.

Verification
REQ-038 Defaults; 640x480 timing; RD_ACK 10 cycles after FRAME_READY -> exactly 2048 WR_EN, addresses 0x000..0x7FF, FRAME_READY rises on the (63,31) write, then RD_BANK=0.
REQ-039 WIN_X0=100, WIN_Y0=50; pixel (100,50)=0x123456 -> WR_ADDR={0,0,0}, WR_DATA=0x123456; pixels (99,50) and (164,50) -> no write.
REQ-040 RD_ACK withheld for 3 VSYNC edges after READY -> DROP_CNT=3, no WR_EN; then RD_ACK -> swap, capture resumes at the next VSYNC.
REQ-041 RD_ACK on the same cycle as a VSYNC edge in READY -> swap, capture starts that frame, DROP_CNT unchanged.
REQ-042 VSYNC edge after 1000 window writes -> DROP_CNT=1, next frame rewrites the same bank from address {wr_bank,0,0}.
REQ-043 RESET asserted mid-CAPTURE -> all outputs equal reset values the same cycle; no WR_EN until after the next VSYNC edge.
